lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store initiator between the CPU execute/memory stage and the data memory. Accepts one load or store per handshake, checks alignment, and drives a request/acknowledge memory port with word address, byte enables and lane-replicated write data. Extends load data by operation type and returns one response pulse with data and error code. Only one access is in flight at a time.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` stays high without `mem_ack` before a bus error is reported (range 1..255).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  pipeline presents a request.
- `req_ready`  out  1  LSU idle and able to accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_op`  in  3  0 word, 1 byte signed, 2 half signed, 3 byte unsigned, 4 half unsigned; 5–7 illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal op.
- `mem_req`  out  1  memory request, held until ack or timeout.
- `mem_we`  out  1  write strobe qualifier.
- `mem_addr`  out  32  `{req_addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completes access this cycle; `mem_rdata` valid with it.
- `mem_rdata`  in  32  full aligned word.

## Operation
- States: IDLE, BUS, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid && req_ready`, latch all request fields. Illegal op → RESP, err 3. Misaligned (word: addr[1:0]≠0; half: addr[0]≠0) → RESP, err 1. Otherwise → BUS, clear timeout counter. Illegal op takes priority over misaligned.
- BUS: `mem_req`=1, `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` stable from latched fields. On `mem_ack`: capture `mem_rdata`, err 0, → RESP. Else increment counter; when counter reaches `TIMEOUT` without ack → RESP, err 2. Ack in the same cycle as expiry: ack wins, err 0.
- RESP: `resp_valid`=1 for exactly one cycle, then → IDLE.
- Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0].
- Write data: word as-is; half `{2{wdata[15:0]}}`; byte `{4{wdata[7:0]}}`.
- Load data: lane selected by addr[1:0] (byte) or addr[1] (half); signed ops sign-extend from lane MSB, unsigned ops zero-extend; word passes through.
- `mem_be`/`mem_wdata`/`mem_we` are 0 whenever `mem_req`=0.
- `mem_ack` outside BUS is ignored.

## Timing
- Request accepted at edge E0; `mem_req` high in cycle after E0; ack sampled at edge E1; `resp_valid` high in cycle after E1. Zero-wait memory: 3 cycles from acceptance edge to response cycle inclusive; next request accepted at the edge ending RESP.
- Error paths (1, 3) skip BUS: `resp_valid` in cycle after acceptance; `mem_req` never asserted.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, dropped the following cycle with `resp_valid` high.
- `resp_rdata`/`resp_err` hold their values after the pulse until the next response.
- Reset (any state, including BUS mid-request): at the reset edge state → IDLE, counter 0, latched fields 0. Reset values: `req_ready`=1 (after reset), `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0. Pending access is abandoned; no response issued.

## Structure
- Package `lsu_pkg`: op encodings (OP_W, OP_B, OP_H, OP_BU, OP_HU), error codes (ERR_OK, ERR_ALIGN, ERR_TIMEOUT, ERR_OP), state enum.
- One combinational sub-module `lsu_lane`: from op and addr[1:0] produce `be`, replicated write data, and extended load data; the FSM and counter stay in `lsu_ctrl`.

## Test plan
- Store byte op 1, addr 0x0000_0013, wdata 0x0000_00A5, ack in first BUS cycle → mem_addr 0x10, mem_be 1000, mem_wdata 0xA5A5A5A5, resp err 0, rdata 0.
- Load half signed addr 0x22, mem_rdata 0x8001_7FFF → rdata 0xFFFF_8001; same with op 4 → 0x0000_8001; op 3 at addr 0x21, mem_rdata 0x0000_F000 → 0x0000_00F0.
- Word load addr 0x6 → no mem_req, resp next cycle err 1; op 7 at addr 0x6 → err 3.
- TIMEOUT=4, no ack → mem_req high 4 cycles, then resp err 2; repeat with ack on 4th cycle → err 0.
- Back-to-back: req_valid held with 3 requests, zero-wait ack → responses every 3 cycles, req_ready low in BUS/RESP.
- rst asserted in 2nd BUS cycle → mem_req 0 next cycle, no resp_valid, req_ready 1; following load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op/error encodings, FSM states and alignment rule for the load/store unit
package lsu_pkg;
  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_B  = 3'd1;
  localparam logic [2:0] OP_H  = 3'd2;
  localparam logic [2:0] OP_BU = 3'd3;
  localparam logic [2:0] OP_HU = 3'd4;
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OP      = 2'd3;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    return (op == OP_W && a != 2'b00) || ((op == OP_H || op == OP_HU) && a[0]);
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte-lane steering for stores (enables, replication) and loads (select, extend)
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic        is_b;
  logic        is_h;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;
  // decode access size, then steer lanes in both directions
  always_comb begin
    is_b      = op == OP_B || op == OP_BU;
    is_h      = op == OP_H || op == OP_HU;
    b_lane    = rdata[{addr_lo, 3'b000} +: 8];
    h_lane    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be        = is_b ? 4'b0001 << addr_lo : is_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    rdata_ext = op == OP_B  ? {{24{b_lane[7]}}, b_lane} :
                op == OP_BU ? {24'b0, b_lane} :
                op == OP_H  ? {{16{h_lane[15]}}, h_lane} :
                op == OP_HU ? {16'b0, h_lane} : rdata;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store initiator with alignment check and bus timeout
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  lsu_lane u_lane (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_req    = state_q == BUS;
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_be     = mem_req ? be : 4'b0000;
  assign mem_wdata  = mem_req ? wdata_rep : 32'b0;

  // next state, request latch, timeout counter and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = 8'd0;
        rdata_d = 32'b0;
        err_d   = req_op > OP_HU ? ERR_OP : misaligned(req_op, req_addr[1:0]) ? ERR_ALIGN : ERR_OK;
        state_d = (req_op > OP_HU || misaligned(req_op, req_addr[1:0])) ? RESP : BUS;
      end
      BUS: if (mem_ack) begin
        rdata_d = we_q ? 32'b0 : rdata_ext;
        err_d   = ERR_OK;
        state_d = RESP;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        rdata_d = 32'b0;
        err_d   = ERR_TIMEOUT;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized transactions checked against a transaction-level model
module tb_lsu_ctrl;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int vectors = 0;
  int miscompares = 0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_misal(input int op, input logic [31:0] a);
    return (op == 0 && a % 4 != 0) || ((op == 2 || op == 4) && a % 2 != 0);
  endfunction

  function automatic logic [31:0] m_be(input int op, input logic [31:0] a);
    if (op == 1 || op == 3) return 32'(1 << (a % 4));
    if (op == 2 || op == 4) return (a % 4) >= 2 ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] w);
    if (op == 1 || op == 3) return (w & 32'hFF) * 32'h0101_0101;
    if (op == 2 || op == 4) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input int op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] lane;
    if (op == 1 || op == 3) begin
      lane = (w >> (8 * (a % 4))) & 32'hFF;
      return (op == 1 && lane >= 128) ? lane - 32'd256 : lane;
    end
    if (op == 2 || op == 4) begin
      lane = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      return (op == 2 && lane >= 32768) ? lane - 32'd65536 : lane;
    end
    return w;
  endfunction

  // one complete access; ack_at = BUS cycle index of the ack, or >= TO for none
  task automatic txn(input logic we, input int op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    logic [31:0] e;
    logic [31:0] er;
    bit done;
    e = op > 4 ? 3 : m_misal(op, addr) ? 1 : 0;
    er = 0;
    done = 0;
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_op = 3'(op); req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (e == 0) begin
      for (int k = 0; k < TO && !done; k++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, addr & ~32'd3);
        chk("mem_be", mem_be, m_be(op, addr));
        if (we) chk("mem_wdata", mem_wdata, m_wdata(op, wd));
        chk("ready_bus", req_ready, 0);
        chk("resp_in_bus", resp_valid, 0);
        mem_ack = (k == ack_at);
        mem_rdata = (k == ack_at) ? rd : $urandom;
        @(negedge clk);
        mem_ack = 0;
        if (k == ack_at) begin
          done = 1;
          er = we ? 0 : m_rdata(op, addr, rd);
        end
      end
      if (!done) e = 2;
    end
    chk("mem_req_resp", mem_req, 0);
    chk("mem_be_idle", mem_be, 0);
    chk("mem_we_idle", mem_we, 0);
    chk("mem_wdata_idle", mem_wdata, 0);
    chk("resp_valid", resp_valid, 1);
    chk("resp_err", resp_err, e);
    chk("resp_rdata", resp_rdata, er);
    chk("ready_resp", req_ready, 0);
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
    chk("ready_after", req_ready, 1);
    chk("err_hold", resp_err, e);
    chk("rdata_hold", resp_rdata, er);
  endtask

  initial begin
    int pulses;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 0;
    txn(1, 1, 32'h13, 32'hA5, 32'h0, 0);
    txn(0, 2, 32'h22, 0, 32'h8001_7FFF, 0);
    txn(0, 4, 32'h22, 0, 32'h8001_7FFF, 1);
    txn(0, 3, 32'h21, 0, 32'h0000_F000, 0);
    txn(0, 0, 32'h6, 0, 0, 0);
    txn(0, 7, 32'h6, 0, 0, 0);
    txn(1, 5, 32'h8, 32'h1234, 0, 0);
    txn(1, 4, 32'h7, 32'h1234, 0, 0);
    txn(0, 0, 32'h100, 0, 32'hDEAD_BEEF, TO);
    txn(0, 0, 32'h104, 0, 32'hCAFE_F00D, TO - 1);
    txn(1, 2, 32'h1F2, 32'hBEEF_5A3C, 0, 2);
    // back-to-back: request and ack held high, IDLE/BUS/RESP repeats every 3 cycles
    pulses = 0;
    req_valid = 1; req_we = 0; req_op = 3'd0; req_addr = 32'h200; mem_ack = 1; mem_rdata = 32'h1357_9BDF;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", req_ready, (i % 3) == 0);
      chk("b2b_mem_req", mem_req, (i % 3) == 1);
      chk("b2b_resp", resp_valid, (i % 3) == 2);
      if (resp_valid) begin
        pulses++;
        chk("b2b_rdata", resp_rdata, 32'h1357_9BDF);
      end
      @(negedge clk);
    end
    req_valid = 0; mem_ack = 0;
    chk("b2b_pulses", pulses, 3);
    @(negedge clk);
    txn(0, 0, 32'h300, 0, 0, TO);
    // reset during the second BUS cycle abandons the access
    req_valid = 1; req_we = 1; req_op = 3'd0; req_addr = 32'h440; req_wdata = 32'h55AA_55AA;
    @(negedge clk);
    req_valid = 0;
    chk("rst_bus1", mem_req, 1);
    @(negedge clk);
    chk("rst_bus2", mem_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_resp", resp_valid, 0);
    chk("rstmid_ready", req_ready, 1);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_err", resp_err, 0);
    chk("rstmid_rdata", resp_rdata, 0);
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_resp", resp_valid, 0);
      chk("rstmid_no_req", mem_req, 0);
    end
    mem_ack = 0;
    txn(0, 1, 32'h442, 0, 32'h0080_0000, 0);
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      txn(1'($urandom), int'($urandom_range(0, 7)), a, $urandom, $urandom, int'($urandom_range(0, 5)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
